// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs
// AXI4-Lite slave register bank. It terminates CPU-side AXI4-Lite reads and
// writes, holds a bank of byte-strobed RW control registers (index 1 and up)
// plus a read-only ID register at index 0, and exports the register contents
// and per-register write pulses to the core logic.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   s_aw*, s_w*, s_b*       AXI4-Lite write address / data / response channels
//   s_ar*, s_r*             AXI4-Lite read address / data channels
//   reg_out                 flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse                one-cycle pulse on bit i after reg i accepts an OKAY write
//
// Write FSM:
//   state   | meaning
//   WR_IDLE | collecting AW and W (either order, or together)
//   WR_RESP | write committed, holding B until s_bready
// Read FSM:
//   state   | meaning
//   RD_IDLE | ready for AR
//   RD_DATA | holding R until s_rready
module axi4_lite_slave_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'hC1A7_0001
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [2:0]                     s_awprot,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [2:0]                     s_arprot,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  localparam logic [DATA_WIDTH-1:0] ID_EXT = DATA_WIDTH'(ID_VALUE);

  // Range check uses the full shifted address so high addresses never alias
  // back into the bank.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> ADDR_LSB);
  endfunction

  // regs[0] is held at the ID constant and never written, so the bank can be
  // read and exported uniformly.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [0:0]            wr_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_ok;
  logic [IDX_W-1:0]      wr_idx;

  logic [0:0]            rd_state;
  logic                  ar_hs;
  logic                  rd_ok;
  logic [IDX_W-1:0]      rd_idx;

  logic                  unused_prot;
  assign unused_prot = ^{s_awprot, s_arprot};

  assign s_awready = (wr_state == WR_IDLE) && !aw_held;
  assign s_wready  = (wr_state == WR_IDLE) && !w_held;
  assign s_arready = (rd_state == RD_IDLE);

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // A handshake on the commit edge is used directly instead of the latch.
  assign wr_addr = aw_held ? awaddr_q : s_awaddr;
  assign wr_data = w_held  ? wdata_q  : s_wdata;
  assign wr_strb = w_held  ? wstrb_q  : s_wstrb;
  assign commit  = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok   = addr_in_range(wr_addr);
  assign wr_idx  = addr_idx(wr_addr);

  assign rd_ok  = addr_in_range(s_araddr);
  assign rd_idx = addr_idx(s_araddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0) ? ID_EXT : '0;
      end
    end else begin
      wr_pulse <= '0;
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= s_awaddr;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
          end
          if (commit) begin
            wr_state <= WR_RESP;
            s_bvalid <= 1'b1;
            s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok && (wr_idx != '0)) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                  regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
              end
              wr_pulse[wr_idx] <= 1'b1;
            end
          end
        end
        default: begin
          if (s_bready) begin
            wr_state <= WR_IDLE;
            s_bvalid <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Read data is captured from the pre-edge bank, so a same-edge write
  // commit is not visible to this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_DATA;
            s_rvalid <= 1'b1;
            s_rdata  <= rd_ok ? regs[rd_idx] : '0;
            s_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: begin
          if (s_rready) begin
            rd_state <= RD_IDLE;
            s_rvalid <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed steps with a
// reference model of the bank and queues of expected B/R responses.
module tb_axi4_lite_slave_regs;

  localparam int NREG = 8;
  localparam logic [31:0] ID = 32'hC1A7_0001;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       s_awaddr;
  logic [2:0]        s_awprot;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [31:0]       s_araddr;
  logic [2:0]        s_arprot;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [NREG*32-1:0] reg_out;
  logic [NREG-1:0]   wr_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model [NREG];
  rexp_t       rq [$];
  logic [1:0]  bq [$];

  always #5 clk = ~clk;

  axi4_lite_slave_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests_run++;
    assert (obs === exp_v)
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = (i == 0) ? ID : 32'h0;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_reg%0d", tag, i), reg_out[i*32 +: 32], model[i]);
  endtask

  // Returns the expected pulse vector and updates the model.
  function automatic logic [NREG-1:0] model_write(input logic [31:0] addr,
                                                  input logic [31:0] data,
                                                  input logic [3:0] strb);
    int idx;
    idx = int'(addr >> 2);
    if (idx >= NREG) begin
      bq.push_back(2'b10);
      return '0;
    end
    bq.push_back(2'b00);
    if (idx == 0) return '0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    return NREG'(1) << idx;
  endfunction

  function automatic void model_read(input logic [31:0] addr);
    rexp_t e;
    int idx;
    idx = int'(addr >> 2);
    if (idx >= NREG) begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end else begin
      e.data = model[idx];
      e.resp = 2'b00;
    end
    rq.push_back(e);
  endfunction

  task automatic pop_b(input string tag);
    logic [1:0] eb;
    eb = bq.pop_front();
    check({tag, "_bresp"}, s_bresp, eb);
  endtask

  task automatic pop_r(input string tag);
    rexp_t e;
    e = rq.pop_front();
    check({tag, "_rdata"}, s_rdata, e.data);
    check({tag, "_rresp"}, s_rresp, e.resp);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [NREG-1:0] exp_pulse;
    logic got;
    exp_pulse = model_write(addr, data, strb);
    @(posedge clk); #1;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_awready && s_wready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("wr_accept", got, 1'b1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("wr_bvalid_latency", s_bvalid, 1'b1);
    check("wr_pulse", wr_pulse, exp_pulse);
    pop_b("wr");
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_bvalid_clear", s_bvalid, 1'b0);
    check("wr_pulse_clear", wr_pulse, '0);
  endtask

  task automatic axi_read(input logic [31:0] addr);
    logic got;
    model_read(addr);
    @(posedge clk); #1;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_arready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rd_accept", got, 1'b1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    check("rd_rvalid_latency", s_rvalid, 1'b1);
    pop_r("rd");
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_rvalid_clear", s_rvalid, 1'b0);
    check("rd_arready_back", s_arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b1;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    model_reset();
    #1;
    check("rst_awready", s_awready, 1'b1);
    check("rst_wready", s_wready, 1'b1);
    check("rst_arready", s_arready, 1'b1);
    check("rst_bvalid", s_bvalid, 1'b0);
    check("rst_rvalid", s_rvalid, 1'b0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_wr_pulse", wr_pulse, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bank("reset");

    // ID register and an empty RW register
    axi_read(32'h00);
    axi_read(32'h04);

    // full-word then partial-strobe writes
    axi_write(32'h04, 32'hDEAD_BEEF, 4'hF);
    axi_read(32'h04);
    axi_write(32'h04, 32'h1122_3344, 4'h5);
    check("strb_merge", reg_out[32 +: 32], 32'hDE22_BE44);
    axi_read(32'h04);

    // W three cycles ahead of AW, B back-pressured for four cycles
    begin
      logic [NREG-1:0] exp_pulse;
      exp_pulse = model_write(32'h0C, 32'h0BAD_F00D, 4'hF);
      @(posedge clk); #1;
      s_bready = 1'b0;
      s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
      @(negedge clk);
      check("early_w_wready", s_wready, 1'b1);
      @(posedge clk); #1;
      s_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("early_w_held_wready", s_wready, 1'b0);
        check("early_w_awready", s_awready, 1'b1);
        check("early_w_no_commit", s_bvalid, 1'b0);
        check("early_w_reg", reg_out[3*32 +: 32], 32'h0);
        @(posedge clk); #1;
      end
      s_awaddr = 32'h0C; s_awvalid = 1'b1;
      @(negedge clk);
      check("late_aw_awready", s_awready, 1'b1);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      @(negedge clk);
      pop_b("late_aw");
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        check("bp_bvalid", s_bvalid, 1'b1);
        check("bp_bresp", s_bresp, 2'b00);
        check("bp_awready", s_awready, 1'b0);
        check("bp_wready", s_wready, 1'b0);
        check("bp_pulse", wr_pulse, (i == 0) ? exp_pulse : '0);
        @(posedge clk); #1;
      end
      s_bready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_bvalid_clear", s_bvalid, 1'b0);
      check("bp_awready_back", s_awready, 1'b1);
      check("bp_wready_back", s_wready, 1'b1);
      check("bp_reg3", reg_out[3*32 +: 32], 32'h0BAD_F00D);
    end

    // out-of-range and ID writes
    axi_write(32'h20, 32'hFFFF_FFFF, 4'hF);
    axi_read(32'h20);
    check_bank("oor");
    axi_write(32'h00, 32'h0, 4'hF);
    axi_read(32'h00);

    // read and write commit to reg 2 on the same edge
    axi_write(32'h08, 32'hA5A5_A5A5, 4'hF);
    begin
      logic got;
      model_read(32'h08);
      void'(model_write(32'h08, 32'h5A5A_5A5A, 4'hF));
      @(posedge clk); #1;
      s_araddr = 32'h08; s_arvalid = 1'b1; s_rready = 1'b0;
      s_awaddr = 32'h08; s_wdata = 32'h5A5A_5A5A; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
      @(negedge clk);
      got = s_arready && s_awready && s_wready;
      check("same_edge_ready", got, 1'b1);
      @(posedge clk); #1;
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      @(negedge clk);
      check("same_edge_rvalid", s_rvalid, 1'b1);
      check("same_edge_bvalid", s_bvalid, 1'b1);
      pop_r("same_edge");
      pop_b("same_edge");
      @(posedge clk); #1;
      @(negedge clk);
      check("same_edge_r_stable", s_rdata, 32'hA5A5_A5A5);
      check("same_edge_rvalid_held", s_rvalid, 1'b1);
      s_rready = 1'b1;
      @(posedge clk); #1;
    end
    axi_read(32'h08);

    // reset while a read response is pending
    model_read(32'h08);
    @(posedge clk); #1;
    s_araddr = 32'h08; s_arvalid = 1'b1; s_rready = 1'b0;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid_before", s_rvalid, 1'b1);
    pop_r("rst_mid");
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", s_rvalid, 1'b0);
    check("rst_mid_reg2", reg_out[2*32 +: 32], 32'h0);
    check("rst_mid_arready", s_arready, 1'b1);
    model_reset();
    rq.delete();
    s_rready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(32'h08);
    axi_read(32'h00);
    check_bank("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite slave register bank. It is the first stage inside template_project, directly downstream of the CPU-side AXI4-Lite master port (s_axi_cpu).
- Terminates write and read transactions.
- Holds a small bank of byte-strobed control registers plus one read-only ID register.
- Exports register contents and per-register write pulses to core logic.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR
DATA_WIDTH, 32, data width; must be 32 or 64
NUM_REGS, 8, registers in the bank, index 0..NUM_REGS-1
ID_VALUE, 32'hC1A7_0001, constant returned by register 0 (zero-extended to DATA_WIDTH)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_WIDTH  write address
s_awprot  in  3  write protection; ignored
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arprot  in  3  read protection; ignored
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  flat register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]; slice 0 = ID_VALUE
wr_pulse  out  NUM_REGS  one-cycle pulse on bit i when reg i is written with OKAY

Behaviour:
Reset and address decode:
- Reset (asynchronous, rst_n=0): all RW regs = 0.
- Reset values: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, wr_pulse=0.
- Reset mid-transaction drops any latched AW/W/AR and any pending B/R; there is no recovery.
- Decode: idx = addr >> log2(DATA_WIDTH/8). Address low byte-offset bits are ignored.
- idx >= NUM_REGS -> SLVERR (2'b10). Otherwise OKAY (2'b00).

Write channel (FSM WR_IDLE, WR_RESP):
- WR_IDLE: s_awready = !aw_held; s_wready = !w_held. AW and W are accepted independently in either order, or in the same cycle; each is latched (aw_held/w_held).
- Commit happens on the edge where both are held, counting a handshake occurring on that same edge.
- On commit, if idx is in range 1..NUM_REGS-1:
  - Each byte lane with wstrb=1 is updated.
  - wr_pulse[idx]=1 for exactly the following cycle, even when wstrb=0.
- idx 0 write: register unchanged, bresp=OKAY, no pulse.
- Out-of-range write: nothing changes, bresp=SLVERR.
- Commit also sets s_bvalid=1 and moves to WR_RESP.
- Latency: AW+W same-edge handshake at edge N -> register updated and s_bvalid=1 after edge N.
- WR_RESP: s_awready=s_wready=0. s_bvalid and s_bresp are held stable until s_bready=1.
- On B handshake: s_bvalid=0, held flags cleared, readies=1 next cycle, return to WR_IDLE.

Read channel (FSM RD_IDLE, RD_DATA), independent of the write channel:
- RD_IDLE: s_arready=1.
- On AR handshake at edge N: s_rdata/s_rresp are registered from the current (pre-edge) register value; s_rvalid=1 after edge N; go to RD_DATA.
- Out-of-range read: rdata=0, rresp=SLVERR.
- RD_DATA: s_arready=0. s_rvalid/s_rdata/s_rresp are held stable until s_rready=1, then s_rvalid=0, s_arready=1, return to RD_IDLE.
- Read and write commit to the same register on the same edge: the read returns the old value.

Other rules:
- No outputs depend combinationally on inputs.
- At most one outstanding write and one outstanding read.

Test Plan:
- Reset then idle -> all readies=1, bvalid=rvalid=0; read 0x00 -> rdata=0xC1A70001, OKAY; read 0x04 -> 0x00000000.
- Write 0x04=0xDEADBEEF, strb=0xF, AW+W same cycle, bready=1 -> bvalid one cycle after handshake, OKAY, wr_pulse[1] one cycle; read 0x04 -> 0xDEADBEEF.
- Write 0x04=0x11223344, strb=0x5 -> reg1=0xDE22BE44; wr_pulse[1]=1 once.
- W presented 3 cycles before AW; bready held 0 for 4 cycles -> bvalid/bresp stable, awready=wready=0 throughout; commit only after AW arrives.
- Write 0x20 (idx 8) and read 0x20 -> bresp=SLVERR, rresp=SLVERR, rdata=0, no wr_pulse, bank unchanged; write 0x00=0x0 -> OKAY, ID unchanged.
- AR to 0x08 and write commit to 0x08 on the same edge (old 0xA5A5A5A5, new 0x5A5A5A5A) -> rdata=0xA5A5A5A5, next read =0x5A5A5A5A; assert rst_n=0 during RD_DATA -> rvalid=0 immediately, reg2=0.
